// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C responder block.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        IGNORE
    } i2c_slv_state_e;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stability filter for one I2C line.
// Also provides single-cycle rise/fall strobes of the filtered level.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic          sync1;
    logic          sync2;
    logic          level_q;
    logic [CW-1:0] cnt;

    // The level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_q <= 1'b1;
            cnt     <= '0;
        end else begin
            sync1   <= pad;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a small register file and auto-incrementing pointer.
// Never drives SCL; SDA is open-drain through sda_padoen_o.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 8,
    parameter int         FILTER_LEN = 3
) (
    input  logic                        wb_clk_i,
    input  logic                        arst_i,
    input  logic                        scl_pad_i,
    input  logic                        sda_pad_i,
    output logic                        sda_pad_o,
    output logic                        sda_padoen_o,
    output logic                        busy_o,
    output logic                        start_o,
    output logic                        stop_o,
    output logic                        wr_o,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_addr_i,
    output logic [7:0]                  dbg_data_o
);

    localparam int PW = $clog2(NUM_REGS);

    i2c_slv_state_e state, state_n;
    logic [3:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shreg, shreg_n;
    logic [PW-1:0]  ptr, ptr_n;
    logic           rw, rw_n;
    logic           first_byte, first_byte_n;
    logic           oen, oen_n;
    logic           busy, busy_n;
    logic           we;
    logic [7:0]     regs [NUM_REGS];
    logic [7:0]     rx_byte;

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (wb_clk_i),
        .rst_n (arst_i),
        .pad   (scl_pad_i),
        .level (scl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (wb_clk_i),
        .rst_n (arst_i),
        .pad   (sda_pad_i),
        .level (sda),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;
    assign rx_byte   = {shreg[6:0], sda};

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            ptr        <= '0;
            rw         <= I2C_WRITE;
            first_byte <= 1'b0;
            oen        <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            ptr        <= ptr_n;
            rw         <= rw_n;
            first_byte <= first_byte_n;
            oen        <= oen_n;
            busy       <= busy_n;
        end
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[ptr] <= rx_byte;
        end
    end

    // Bus conditions preempt bit handling; SDA only moves after an SCL fall.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        ptr_n        = ptr;
        rw_n         = rw;
        first_byte_n = first_byte;
        oen_n        = oen;
        busy_n       = busy;
        we           = 1'b0;
        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            oen_n     = 1'b1;
            busy_n    = 1'b1;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            oen_n     = 1'b1;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_n = ADDR_ACK;
                                rw_n    = rx_byte[0];
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        oen_n = I2C_ACK;
                    end else if (scl_rise && bit_cnt == 4'd8) begin
                        bit_cnt_n = 4'd9;
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        bit_cnt_n = '0;
                        if (state == ADDR_ACK && rw == I2C_READ) begin
                            state_n = TX;
                            shreg_n = regs[ptr];
                            oen_n   = regs[ptr][7];
                        end else begin
                            state_n = RX;
                            oen_n   = 1'b1;
                            if (state == ADDR_ACK) first_byte_n = 1'b1;
                        end
                    end
                end
                RX: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state_n = RX_ACK;
                            if (first_byte) begin
                                ptr_n        = rx_byte[PW-1:0];
                                first_byte_n = 1'b0;
                            end else begin
                                we    = 1'b1;
                                ptr_n = ptr + 1'b1;
                            end
                        end
                    end
                end
                TX: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_n = TX_ACK;
                            oen_n   = 1'b1;
                        end else begin
                            oen_n   = shreg[6];
                            shreg_n = {shreg[6:0], 1'b0};
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        ptr_n = ptr + 1'b1;
                        if (sda == I2C_NACK) state_n = IGNORE;
                        else bit_cnt_n = 4'd9;
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        state_n   = TX;
                        bit_cnt_n = '0;
                        shreg_n   = regs[ptr];
                        oen_n     = regs[ptr][7];
                    end
                end
                IDLE, IGNORE: begin
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = oen;
    assign busy_o       = busy;
    assign start_o      = start_det;
    assign stop_o       = stop_det;
    assign wr_o         = we;
    assign dbg_data_o   = regs[dbg_addr_i];

endmodule
